// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shared types, port ids and width helper for the shift request arbiter
package shift_arb_pkg;

   typedef logic port_id_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   function automatic int data_width(input int n);
      return 2 ** n;
   endfunction

endpackage

// File: rtl/shift_arb_datapath.sv
// shift_arb_datapath: combinational W-bit logical right shifter; rotate-right added when SHIFT_ARB_ROTATE_EN is defined
module shift_arb_datapath
   import shift_arb_pkg::*;
#(
   parameter  int N = 2,
   localparam int W = data_width(N)
) (
   input  logic [W-1:0] a,
   input  logic [N-1:0] amt,
`ifdef SHIFT_ARB_ROTATE_EN
   input  logic         rot,
`endif
   output logic [W-1:0] y
);

`ifdef SHIFT_ARB_ROTATE_EN
   logic [N:0] back;

   // rotate wraps the bits shifted out back in from the top; amt=0 makes back=W so the wrap term vanishes
   always_comb begin
      back = (N+1)'(W) - {1'b0, amt};
      y    = rot ? ((a >> amt) | (a << back)) : (a >> amt);
   end
`else
   // logical shift with zero fill
   always_comb begin
      y = a >> amt;
   end
`endif

endmodule

// File: rtl/shift_req_arbiter.sv
// shift_req_arbiter: round-robin arbiter sharing one right-shift datapath between two valid/ready requesters
// with a single-entry registered output buffer; SHIFT_ARB_ROTATE_EN adds per-port rotate select inputs
module shift_req_arbiter
   import shift_arb_pkg::*;
#(
   parameter  int N = 2,
   localparam int W = data_width(N)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [N-1:0] req0_amt,
`ifdef SHIFT_ARB_ROTATE_EN
   input  logic         req0_rot,
`endif
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [N-1:0] req1_amt,
`ifdef SHIFT_ARB_ROTATE_EN
   input  logic         req1_rot,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_y,
   output logic         out_src
);

   buf_state_t   state;
   port_id_t     prio;
   port_id_t     gnt;
   logic         any_valid;
   logic         can_accept;
   logic         xfer;
   logic [W-1:0] sel_a;
   logic [N-1:0] sel_amt;
   logic [W-1:0] sel_y;
`ifdef SHIFT_ARB_ROTATE_EN
   logic         sel_rot;
`endif

   assign out_valid = (state == FULL);

   // grant the lone requester, or the favoured one on contention; the buffer accepts when empty or draining
   always_comb begin
      any_valid  = req0_valid || req1_valid;
      gnt        = (req0_valid && req1_valid) ? prio : (req1_valid ? PORT1 : PORT0);
      can_accept = !out_valid || out_ready;
      xfer       = any_valid && can_accept;
      req0_ready = xfer && gnt == PORT0;
      req1_ready = xfer && gnt == PORT1;
      sel_a      = (gnt == PORT1) ? req1_a : req0_a;
      sel_amt    = (gnt == PORT1) ? req1_amt : req0_amt;
`ifdef SHIFT_ARB_ROTATE_EN
      sel_rot    = (gnt == PORT1) ? req1_rot : req0_rot;
`endif
   end

   shift_arb_datapath #(.N(N)) u_dp (
      .a   (sel_a),
      .amt (sel_amt),
`ifdef SHIFT_ARB_ROTATE_EN
      .rot (sel_rot),
`endif
      .y   (sel_y)
   );

   // output buffer and priority pointer; a transfer loads and flips priority, a drain without transfer empties
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= EMPTY;
         out_y   <= '0;
         out_src <= PORT0;
         prio    <= PORT0;
      end else if (xfer) begin
         state   <= FULL;
         out_y   <= sel_y;
         out_src <= gnt;
         prio    <= ~gnt;
      end else if (out_ready) begin
         state   <= EMPTY;
      end
   end

endmodule
